x25519_stream_if: RTL and testbench

X25519_STREAM_IF -- requirements
Module: x25519_stream_if

---
 rtl/x25519_pkg.sv | 29 ++
 rtl/x25519_clamp.sv | 19 +
 rtl/x25519_stream_if.sv | 186 ++++++++++++++++++
 tb/tb_x25519_stream_if.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/x25519_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : x25519_pkg
//  Description : Shared types and constants for the X25519 byte-stream
//                wrapper: FSM state encoding, field width, byte count,
//                base-point u-coordinate and scalar clamp masks.
//  Revision    : 1.0 - initial release
// ============================================================================
package x25519_pkg;

    localparam int FE_W   = 255;
    localparam int NBYTES = 32;

    localparam logic [FE_W-1:0] BASE_U = 255'd9;

    // Clamp: force bit 254 high, force bits [2:0] low.
    localparam logic [FE_W-1:0] CLAMP_SET = {1'b1, {(FE_W-1){1'b0}}};
    localparam logic [FE_W-1:0] CLAMP_CLR = {{(FE_W-3){1'b0}}, 3'b111};

    typedef enum logic [2:0] {
        LOAD_K = 3'd0,
        LOAD_U = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        SEND   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/x25519_clamp.sv
`default_nettype none
// ============================================================================
//  Module      : x25519_clamp
//  Description : Combinational X25519 scalar clamp on a 255-bit operand
//                (bit 254 set, bits [2:0] cleared, all else passed through).
//  Revision    : 1.0 - initial release
// ============================================================================
module x25519_clamp
    import x25519_pkg::*;
(
    input  logic [FE_W-1:0] scalar_in,
    output logic [FE_W-1:0] scalar_out
);

    // Mask-based form keeps every input bit in the cone of logic.
    assign scalar_out = (scalar_in | CLAMP_SET) & ~CLAMP_CLR;

endmodule
`default_nettype wire

// File: rtl/x25519_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : x25519_stream_if
//  Description : Byte-stream front end for an external curve25519 core.
//                Collects 32 scalar bytes and 32 u-coordinate bytes
//                (little-endian), pulses core_start, waits for core_done
//                (ignoring it for DONE_GUARD cycles), then streams the
//                32-byte result out with valid/ready handshaking.
//                Optional build macro X25519_BASEPOINT_EN adds in_base,
//                which skips u-coordinate loading and uses u = 9.
//  Revision    : 1.0 - initial release
// ============================================================================
module x25519_stream_if
    import x25519_pkg::*;
#(
    parameter int DONE_GUARD = 1
)
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_data,
`ifdef X25519_BASEPOINT_EN
    input  logic            in_base,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic            out_last,
    output logic            out_zero,
    output logic            busy,
    output logic            core_start,
    output logic [FE_W-1:0] core_scalar,
    output logic [FE_W-1:0] core_point,
    input  logic            core_done,
    input  logic [FE_W-1:0] core_out
);

    localparam int c_guard_w = (DONE_GUARD < 1) ? 1 : $clog2(DONE_GUARD + 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [4:0]             r_cnt;
    logic [FE_W-1:0]        r_k;
    logic [FE_W-1:0]        r_u;
    logic [8*NBYTES-1:0]    r_res;
    logic                   r_zero;
    logic [c_guard_w-1:0]   r_guard;

    logic                   w_in_acc;
    logic                   w_out_acc;
    logic                   w_last_byte;
    logic                   w_capture;
    logic                   w_k_wr;
    logic                   w_u_wr;
    logic                   w_op_en;
    logic                   w_skip_u;
    logic [FE_W-1:0]        w_k_clamped;
    logic [FE_W-1:0]        w_u_sel;

    assign w_in_acc    = in_valid && in_ready;
    assign w_out_acc   = out_valid && out_ready;
    assign w_last_byte = (r_cnt == 5'(NBYTES - 1));
    assign w_capture   = (r_state == WAIT) && (r_guard == '0) && core_done;
    assign w_k_wr      = w_in_acc && (r_state == LOAD_K);
    assign w_u_wr      = w_in_acc && (r_state == LOAD_U);
    assign w_op_en     = (r_state == START) || (r_state == WAIT);

`ifdef X25519_BASEPOINT_EN
    logic r_base;

    // Base-point request is latched with scalar byte 0 and held for the op.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                      r_base <= 1'b0;
        else if (w_k_wr && r_cnt == 5'd0)  r_base <= in_base;
    end

    assign w_skip_u = r_base;
    assign w_u_sel  = r_base ? BASE_U : r_u;
`else
    assign w_skip_u = 1'b0;
    assign w_u_sel  = r_u;
`endif

    x25519_clamp u_clamp (
        .scalar_in  (r_k),
        .scalar_out (w_k_clamped)
    );

    // Operands are presented only while the core owns them, zero otherwise.
    assign core_scalar = w_op_en ? w_k_clamped : '0;
    assign core_point  = w_op_en ? w_u_sel     : '0;

    // Result streams LSB-first out of a shift register.
    assign out_data = r_res[7:0];
    assign out_last = out_valid && w_last_byte;
    assign out_zero = out_valid && r_zero;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= LOAD_K;
        else          r_state <= w_next;
    end

    // Next-state and per-state handshake/status outputs.
    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        core_start = 1'b0;
        case (r_state)
            LOAD_K: begin
                in_ready = 1'b1;
                if (w_in_acc && w_last_byte) w_next = w_skip_u ? START : LOAD_U;
            end
            LOAD_U: begin
                in_ready = 1'b1;
                if (w_in_acc && w_last_byte) w_next = START;
            end
            START: begin
                busy       = 1'b1;
                core_start = 1'b1;
                w_next     = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (w_capture) w_next = SEND;
            end
            SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (w_out_acc && w_last_byte) w_next = LOAD_K;
            end
            default: w_next = LOAD_K;
        endcase
    end

    // Byte counter shared by load and send phases; wraps naturally at 31.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                   r_cnt <= 5'd0;
        else if (w_in_acc || w_out_acc) r_cnt <= r_cnt + 5'd1;
    end

    // Operand byte capture; input bit 255 (byte 31 bit 7) is never stored.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_k <= '0;
            r_u <= '0;
        end else begin
            for (int b = 0; b < NBYTES - 1; b++) begin
                if (r_cnt == 5'(b)) begin
                    if (w_k_wr) r_k[8*b +: 8] <= in_data;
                    if (w_u_wr) r_u[8*b +: 8] <= in_data;
                end
            end
            if (w_last_byte) begin
                if (w_k_wr) r_k[FE_W-1 -: 7] <= in_data[6:0];
                if (w_u_wr) r_u[FE_W-1 -: 7] <= in_data[6:0];
            end
        end
    end

    // Guard countdown armed in START, consumed in WAIT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                                r_guard <= '0;
        else if (r_state == START)                   r_guard <= c_guard_w'(DONE_GUARD);
        else if (r_state == WAIT && r_guard != '0)   r_guard <= r_guard - 1'b1;
    end

    // Result capture on the first qualifying core_done, then byte shifting.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_res  <= '0;
            r_zero <= 1'b0;
        end else if (w_capture) begin
            r_res  <= {1'b0, core_out};
            r_zero <= (core_out == '0);
        end else if (w_out_acc) begin
            r_res  <= r_res >> 8;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_x25519_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_x25519_stream_if
//  Description : Directed self-checking bench for x25519_stream_if with a
//                small behavioural curve25519 core stand-in.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_x25519_stream_if;
    import x25519_pkg::*;

    localparam int DONE_GUARD = 1;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [7:0]      in_data = 8'h00;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [7:0]      out_data;
    logic            out_last;
    logic            out_zero;
    logic            busy;
    logic            core_start;
    logic [FE_W-1:0] core_scalar;
    logic [FE_W-1:0] core_point;
    logic            core_done;
    logic [FE_W-1:0] model_result = '0;
    logic            stuck_done = 1'b0;
    logic            pulse_done = 1'b0;
`ifdef X25519_BASEPOINT_EN
    logic            in_base = 1'b0;
`endif

    assign core_done = stuck_done | pulse_done;

    x25519_stream_if #(.DONE_GUARD(DONE_GUARD)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
`ifdef X25519_BASEPOINT_EN
        .in_base     (in_base),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_zero    (out_zero),
        .busy        (busy),
        .core_start  (core_start),
        .core_scalar (core_scalar),
        .core_point  (core_point),
        .core_done   (core_done),
        .core_out    (model_result)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_start = 0;
    int start_cyc = 0;
    int pulse_cnt = 0;
    logic [FE_W-1:0] cap_k = '0;
    logic [FE_W-1:0] cap_u = '0;
    logic [7:0] kb [32];
    logic [7:0] ub [32];

    // Cycle counter and snapshot of operands at each core_start.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (core_start) begin
            n_start   <= n_start + 1;
            start_cyc <= cyc;
            cap_k     <= core_scalar;
            cap_u     <= core_point;
        end
    end

    // Core stand-in: single done pulse ten cycles after start.
    always @(posedge clock) begin
        pulse_done <= 1'b0;
        if (core_start) pulse_cnt <= 10;
        else if (pulse_cnt != 0) begin
            pulse_cnt <= pulse_cnt - 1;
            if (pulse_cnt == 1) pulse_done <= 1'b1;
        end
    end

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        logic acc;
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 64 && !done; t++) begin
            acc = in_ready;
            @(posedge clock); #1;
            if (acc) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) check_val("in_accept_wait", {255'b0, done}, 256'd1);
    endtask

    task automatic load_op(input logic skip_u);
        for (int i = 0; i < 32; i++) begin
`ifdef X25519_BASEPOINT_EN
            in_base = (i == 0) ? skip_u : 1'b0;
`endif
            put_byte(kb[i]);
        end
        if (!skip_u) for (int i = 0; i < 32; i++) put_byte(ub[i]);
    endtask

    function automatic logic [255:0] pack_bytes(input logic use_u);
        logic [255:0] v;
        for (int i = 0; i < 32; i++) v[8*i +: 8] = use_u ? ub[i] : kb[i];
        return v;
    endfunction

    task automatic get_result(input logic [255:0] exp, input logic exp_zero, input logic alt);
        int   i;
        logic stall;
        logic [9:0] held;
        i     = 0;
        stall = 1'b0;
        held  = '0;
        for (int t = 0; t < 400 && i < 32; t++) begin
            out_ready = alt ? ((t % 2) == 0) : 1'b1;
            if (stall) check_val("hold_stable", {246'b0, out_last, out_zero, out_data}, {246'b0, held});
            if (out_valid && out_ready) begin
                check_val($sformatf("out_data[%0d]", i), {248'b0, out_data}, {248'b0, exp[8*i +: 8]});
                check_val($sformatf("out_last[%0d]", i), {255'b0, out_last}, {255'b0, (i == 31)});
                check_val($sformatf("out_zero[%0d]", i), {255'b0, out_zero}, {255'b0, exp_zero});
                i++;
                stall = 1'b0;
            end else if (out_valid) begin
                stall = 1'b1;
                held  = {out_last, out_zero, out_data};
            end else begin
                stall = 1'b0;
            end
            @(posedge clock); #1;
        end
        out_ready = 1'b0;
        if (i < 32) check_val("recv_count", i, 32);
        check_val("post_out_valid", {255'b0, out_valid}, 256'd0);
        check_val("post_in_ready", {255'b0, in_ready}, 256'd1);
    endtask

    initial begin
        logic [FE_W-1:0] e_k;
        logic [FE_W-1:0] e_u;
        logic [255:0]    tmp;
        logic [255:0]    res_b;
        logic [255:0]    res_c;
        int              n0;
        int              t;

        // Reset state with reset held low
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_in_ready", {255'b0, in_ready}, 256'd1);
        check_val("rst_out_valid", {255'b0, out_valid}, 256'd0);
        check_val("rst_out_last", {255'b0, out_last}, 256'd0);
        check_val("rst_out_zero", {255'b0, out_zero}, 256'd0);
        check_val("rst_busy", {255'b0, busy}, 256'd0);
        check_val("rst_core_start", {255'b0, core_start}, 256'd0);
        check_val("rst_core_scalar", {1'b0, core_scalar}, 256'd0);
        check_val("rst_core_point", {1'b0, core_point}, 256'd0);
        check_val("rst_out_data", {248'b0, out_data}, 256'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // A: all-0xFF operands, result 1, continuous out_ready
        for (int i = 0; i < 32; i++) begin kb[i] = 8'hFF; ub[i] = 8'hFF; end
        model_result = 255'd1;
        n0 = n_start;
        load_op(1'b0);
        e_k = '1;
        e_k[2:0] = 3'b000;
        check_val("A_core_start", {255'b0, core_start}, 256'd1);
        check_val("A_scalar", {1'b0, core_scalar}, {1'b0, e_k});
        check_val("A_point", {1'b0, core_point}, {1'b0, {255{1'b1}}});
        in_valid = 1'b1;
        in_data  = 8'h77;
        repeat (3) begin @(posedge clock); #1; end
        check_val("A_wait_in_ready", {255'b0, in_ready}, 256'd0);
        check_val("A_wait_busy", {255'b0, busy}, 256'd1);
        check_val("A_scalar_stable", {1'b0, core_scalar}, {1'b0, e_k});
        in_valid = 1'b0;
        get_result(256'd1, 1'b0, 1'b0);
        check_val("A_start_count", n_start - n0, 1);

        // B: ramp operands, rich result, alternating out_ready
        for (int i = 0; i < 32; i++) begin kb[i] = 8'(i); ub[i] = 8'hA0 + 8'(i); end
        res_b = 256'h7123_4567_89ab_cdef_fedc_ba98_7654_3210_0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;
        model_result = res_b[254:0];
        tmp = pack_bytes(1'b0);
        e_k = tmp[254:0];
        e_k[254] = 1'b1;
        e_k[2:0] = 3'b000;
        tmp = pack_bytes(1'b1);
        e_u = tmp[254:0];
        n0 = n_start;
        load_op(1'b0);
        get_result(res_b, 1'b0, 1'b1);
        check_val("B_scalar", {1'b0, cap_k}, {1'b0, e_k});
        check_val("B_point", {1'b0, cap_u}, {1'b0, e_u});
        check_val("B_start_count", n_start - n0, 1);

        // C: reset after 17 scalar bytes, then a clean operation
        for (int i = 0; i < 32; i++) begin kb[i] = 8'hFF; ub[i] = 8'h00; end
        ub[0] = 8'h09;
        res_c = 256'h4000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0080;
        model_result = res_c[254:0];
        n0 = n_start;
        for (int i = 0; i < 17; i++) put_byte(kb[i]);
        reset_n = 1'b0;
        #2;
        check_val("C_rst_in_ready", {255'b0, in_ready}, 256'd1);
        check_val("C_rst_busy", {255'b0, busy}, 256'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        check_val("C_no_start", n_start - n0, 0);
        load_op(1'b0);
        get_result(res_c, 1'b0, 1'b0);
        e_k = '1;
        e_k[2:0] = 3'b000;
        check_val("C_scalar", {1'b0, cap_k}, {1'b0, e_k});
        check_val("C_point", {1'b0, cap_u}, 256'd9);
        check_val("C_start_count", n_start - n0, 1);

        // D: core_done stuck high, zero result
        for (int i = 0; i < 32; i++) begin kb[i] = 8'h55; ub[i] = 8'h33; end
        model_result = '0;
        stuck_done = 1'b1;
        n0 = n_start;
        load_op(1'b0);
        t = 0;
        while (!out_valid && t < 50) begin @(posedge clock); #1; t++; end
        check_val("D_capture_latency", cyc - start_cyc, DONE_GUARD + 2);
        get_result(256'd0, 1'b1, 1'b0);
        stuck_done = 1'b0;
        tmp = pack_bytes(1'b0);
        e_k = tmp[254:0];
        e_k[254] = 1'b1;
        e_k[2:0] = 3'b000;
        check_val("D_scalar", {1'b0, cap_k}, {1'b0, e_k});
        check_val("D_point", {1'b0, cap_u}, {1'b0, {8'h33, {31{8'h33}}}} & 256'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff);
        check_val("D_start_count", n_start - n0, 1);

`ifdef X25519_BASEPOINT_EN
        // E: base-point request skips the u-coordinate
        tmp = 256'ha546e36bf0527c9d3b16154b82465edd62144c0ac1fc5a18506a2244ba449ac4;
        for (int i = 0; i < 32; i++) begin kb[i] = tmp[255-8*i -: 8]; ub[i] = 8'hEE; end
        model_result = 255'h2A;
        tmp = pack_bytes(1'b0);
        e_k = tmp[254:0];
        e_k[254] = 1'b1;
        e_k[2:0] = 3'b000;
        n0 = n_start;
        load_op(1'b1);
        check_val("E_core_start", {255'b0, core_start}, 256'd1);
        check_val("E_point", {1'b0, core_point}, 256'd9);
        check_val("E_scalar", {1'b0, core_scalar}, {1'b0, e_k});
        get_result(256'h2A, 1'b0, 1'b0);
        check_val("E_start_count", n_start - n0, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
